// File: rtl/pwm_ramp_if.sv
// Control/status bundle between a PWM sequencing master and pwm_ramp_controller.
interface pwm_ramp_if #(
    parameter int unsigned RES_BITS = 4
);
    logic                en;
    logic [1:0]          mode;
    logic [RES_BITS-1:0] duty_in;
    logic                pwm_out;
    logic [RES_BITS-1:0] duty_cur;
    logic                period_done;
    logic [1:0]          state;

    modport master (
        output en, mode, duty_in,
        input  pwm_out, duty_cur, period_done, state
    );

    modport slave (
        input  en, mode, duty_in,
        output pwm_out, duty_cur, period_done, state
    );
endinterface

// File: rtl/pwm_ramp_controller.sv
// PWM counter/prescaler with a manual or auto-ramping duty that is only ever updated at a
// period boundary, so the output never shows a partial period.
module pwm_ramp_controller #(
    parameter int unsigned RES_BITS     = 4,
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned STEP_PERIODS = 8
) (
    input logic       clk,
    input logic       reset,
    pwm_ramp_if.slave bus
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [RES_BITS-1:0] DutyMax  = {RES_BITS{1'b1}};
    localparam logic [PW-1:0]       PcntLast = PW'(PRESCALE - 1);
    localparam logic [SW-1:0]       ScntLast = SW'(STEP_PERIODS - 1);

    typedef enum logic [1:0] {
        StManual = 2'b00,
        StUp     = 2'b01,
        StDown   = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [RES_BITS-1:0] duty_q, duty_d;
    logic [RES_BITS-1:0] cnt_q;
    logic [PW-1:0]       pcnt_q;
    logic [SW-1:0]       scnt_q, scnt_d;
    logic                pwm_q;
    logic                done_q;
    logic                tick, wrap, step, manual;

    assign tick   = bus.en && (pcnt_q == PcntLast);
    assign wrap   = tick && (cnt_q == DutyMax);
    assign step   = wrap && (scnt_q == ScntLast);
    assign manual = (bus.mode == 2'b00) || (bus.mode == 2'b11);

    // Timebase: a disabled engine parks every counter so re-enable starts a clean period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
            pwm_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (!bus.en) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
            pwm_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
            if (tick) begin
                cnt_q <= cnt_q + 1'b1;
            end
            pwm_q  <= cnt_q < duty_q;
            done_q <= wrap;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StManual;
            duty_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            scnt_q  <= scnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        scnt_d  = scnt_q;
        if (!bus.en) begin
            scnt_d = '0;
        end else if (wrap) begin
            if (manual) begin
                state_d = StManual;
                duty_d  = bus.duty_in;
            end else begin
                case (state_q)
                    StUp: begin
                        if (step) begin
                            if (duty_q != DutyMax) begin
                                duty_d = duty_q + 1'b1;
                            end else if (bus.mode == 2'b01) begin
                                state_d = StDown;
                                duty_d  = duty_q - 1'b1;
                            end else begin
                                duty_d = '0;
                            end
                        end
                    end
                    StDown: begin
                        // Sawtooth only ramps upward, so leaving triangle turns around at once.
                        if (bus.mode == 2'b10) begin
                            state_d = StUp;
                        end else if (step) begin
                            if (duty_q != '0) begin
                                duty_d = duty_q - 1'b1;
                            end else begin
                                state_d = StUp;
                                duty_d  = duty_q + 1'b1;
                            end
                        end
                    end
                    default: state_d = StUp;
                endcase
            end
            if ((state_d != state_q) || (state_d == StManual) || step) begin
                scnt_d = '0;
            end else begin
                scnt_d = scnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.pwm_out     = pwm_q;
        bus.duty_cur    = duty_q;
        bus.period_done = done_q;
        bus.state       = state_q;
    end
endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Bench for pwm_ramp_controller: instances with STEP_PERIODS 1 and 2 share one stimulus stream;
// each period's expected duty, state and high-time is queued and checked at period_done.
module tb_pwm_ramp_controller;
    localparam int unsigned RES = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pwm_ramp_if #(.RES_BITS(RES)) bus_a ();
    pwm_ramp_if #(.RES_BITS(RES)) bus_b ();

    pwm_ramp_controller #(
        .RES_BITS     (RES),
        .PRESCALE     (2),
        .STEP_PERIODS (1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pwm_ramp_controller #(
        .RES_BITS     (RES),
        .PRESCALE     (2),
        .STEP_PERIODS (2)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        int hi_a;
        int duty_a;
        int st_a;
        int hi_b;
        int duty_b;
        int st_b;
    } item_t;

    item_t sbq[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    prev_a      = 0;
    int    prev_b      = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: window of 32 samples ends on the sample where period_done is high.
    int    len = 0, hi_a = 0, hi_b = 0;
    int    held_a = 0, held_b = 0, hst_a = 0, hst_b = 0;
    logic  ok_d = 1'b0;
    item_t it;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("reset_outputs_a", int'({bus_a.pwm_out, bus_a.period_done, bus_a.duty_cur,
                                               bus_a.state}), 0);
                check("reset_outputs_b", int'({bus_b.pwm_out, bus_b.period_done, bus_b.duty_cur,
                                               bus_b.state}), 0);
                held_a = 0; held_b = 0; hst_a = 0; hst_b = 0;
                len = 0; hi_a = 0; hi_b = 0;
            end else if (!ok_d) begin
                check("idle_quiet_held_a", int'({bus_a.pwm_out, bus_a.period_done,
                                                 bus_a.duty_cur, bus_a.state}), held_a * 4 + hst_a);
                check("idle_quiet_held_b", int'({bus_b.pwm_out, bus_b.period_done,
                                                 bus_b.duty_cur, bus_b.state}), held_b * 4 + hst_b);
                len = 0; hi_a = 0; hi_b = 0;
            end else begin
                len++;
                hi_a += int'(bus_a.pwm_out);
                hi_b += int'(bus_b.pwm_out);
                if (bus_a.period_done || bus_b.period_done) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_period_done", sbq.size(), 1);
                    end else begin
                        it = sbq.pop_front();
                        check("period_len", len, 32);
                        check("period_done_both", int'(bus_a.period_done && bus_b.period_done), 1);
                        check("hi_clks_a", hi_a, it.hi_a);
                        check("duty_cur_a", int'(bus_a.duty_cur), it.duty_a);
                        check("state_a", int'(bus_a.state), it.st_a);
                        check("hi_clks_b", hi_b, it.hi_b);
                        check("duty_cur_b", int'(bus_b.duty_cur), it.duty_b);
                        check("state_b", int'(bus_b.state), it.st_b);
                        held_a = it.duty_a; held_b = it.duty_b;
                        hst_a  = it.st_a;   hst_b  = it.st_b;
                    end
                    len = 0; hi_a = 0; hi_b = 0;
                end
            end
            ok_d = reset && bus_a.en;
        end
    end

    task automatic drive(input logic e, input logic [1:0] m, input logic [3:0] d);
        bus_a.en = e; bus_a.mode = m; bus_a.duty_in = d;
        bus_b.en = e; bus_b.mode = m; bus_b.duty_in = d;
    endtask

    // One full period from just after a wrap edge to just after the next one.
    task automatic period(input int da, input int sa, input int db, input int sb,
                          input int chg_at = -1, input int chg_duty = 0);
        item_t x;
        x.hi_a = 2 * prev_a; x.duty_a = da; x.st_a = sa;
        x.hi_b = 2 * prev_b; x.duty_b = db; x.st_b = sb;
        sbq.push_back(x);
        prev_a = da;
        prev_b = db;
        for (int c = 0; c < 32; c++) begin
            if (c == chg_at) begin
                bus_a.duty_in = 4'(chg_duty);
                bus_b.duty_in = 4'(chg_duty);
            end
            @(posedge clk);
        end
        #1;
    endtask

    // Abort the running period with reset or en low for 10 clks.
    task automatic interrupt(input int at, input bit use_reset);
        repeat (at) @(posedge clk);
        #1;
        if (use_reset) reset = 1'b0;
        else begin
            bus_a.en = 1'b0;
            bus_b.en = 1'b0;
        end
        repeat (10) @(posedge clk);
        #1;
        if (use_reset) reset = 1'b1;
        else begin
            bus_a.en = 1'b1;
            bus_b.en = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 2'b00, 4'd4);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Manual duty, including a mid-period duty_in change that must wait for the wrap.
        period(4, 0, 4, 0);
        period(4, 0, 4, 0);
        period(12, 0, 12, 0, 12, 12);
        period(12, 0, 12, 0);
        drive(1'b1, 2'b00, 4'd0);
        period(0, 0, 0, 0);
        period(0, 0, 0, 0);
        drive(1'b1, 2'b11, 4'd15);
        period(15, 0, 15, 0);
        period(15, 0, 15, 0);

        drive(1'b1, 2'b00, 4'd0);
        interrupt(10, 1'b1);
        prev_a = 0;
        prev_b = 0;
        period(0, 0, 0, 0);

        // Triangle: A steps every wrap, B every second wrap.
        drive(1'b1, 2'b01, 4'd0);
        for (int k = 0; k < 20; k++) begin
            period((k <= 15) ? k : 30 - k, (k <= 15) ? 1 : 2, k / 2, 1);
        end

        // Sawtooth (A leaves S_DOWN without stepping), then back to triangle from S_UP.
        drive(1'b1, 2'b10, 4'd0);
        for (int j = 0; j < 16; j++) begin
            if (j == 14) drive(1'b1, 2'b01, 4'd0);
            period((11 + j) % 16, 1, ((20 + j) / 2) % 16, 1);
        end

        // Enable gap mid-ramp: duty/state hold, step counter restarts.
        interrupt(8, 1'b0);
        period(11, 1, 1, 1);
        period(12, 1, 2, 1);
        period(13, 1, 2, 1);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Sequencing controller for the board's PWM datapath. It owns the PWM counter and prescaler and produces a glitch-free PWM output. The duty cycle it applies either follows a manual value or ramps automatically (triangle or sawtooth fade), and every change is applied only at a PWM period boundary. The applied duty is exported for the seven-segment display path and for the LEDs, and a per-period strobe is exported for other sequencers.

## Interface
- RES_BITS, 4: duty/counter resolution; period = 2^RES_BITS PWM ticks.
- PRESCALE, 1000: clk cycles per PWM tick (≥1).
- STEP_PERIODS, 8: PWM periods per ramp step (≥1).
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low holds the engine idle.
- mode  in  2  00 manual, 01 triangle ramp, 10 sawtooth ramp, 11 treated as 00.
- duty_in  in  RES_BITS  manual duty value, sampled at period boundary.
- pwm_out  out  1  registered PWM output.
- duty_cur  out  RES_BITS  duty currently applied (for display/LEDs).
- period_done  out  1  one-cycle pulse at each period wrap.
- state  out  2  FSM state: 00 S_MANUAL, 01 S_UP, 10 S_DOWN.

## Operation
- Prescaler pcnt counts 0..PRESCALE-1. tick = en && pcnt==PRESCALE-1. On tick pcnt returns to 0.
- PWM counter cnt (RES_BITS) increments on tick and wraps 2^RES_BITS-1 → 0.
- wrap = tick && cnt==max. period_done is registered: it equals wrap delayed by one cycle.
- pwm_out <= en && (cnt < duty_cur), registered every cycle. The compare is unsigned.
  - duty 0 gives constant low.
  - duty max gives high for (2^RES_BITS-1)/2^RES_BITS of the period. 100% duty is not reachable, by design.
- duty_cur and state change only on wrap cycles (shadow-register behaviour), so there are no partial periods.
- Step counter scnt counts wraps 0..STEP_PERIODS-1. step = wrap && scnt==STEP_PERIODS-1. scnt clears when mode is re-evaluated into a new state.
- FSM, evaluated on wrap:
  - mode 00/11: next state S_MANUAL; duty_cur <= duty_in.
  - Entering a ramp from S_MANUAL: go to S_UP with duty_cur unchanged and scnt cleared.
  - S_UP, on step:
    - if duty_cur < max, increment it.
    - else, for triangle (01), go to S_DOWN and decrement.
    - else, for sawtooth (10), wrap duty_cur to 0 and stay in S_UP.
  - S_DOWN, on step:
    - if duty_cur > 0, decrement it.
    - else go to S_UP and increment.
  - Mode switched 01 → 10 while in S_DOWN: go to S_UP on the next wrap, duty unchanged.
  - Mode switched 10 → 01: keep the current state.
- en low:
  - synchronously clears pcnt, cnt and scnt; pwm_out is 0 on the next cycle; period_done is 0.
  - duty_cur and state hold.
  - On re-enable the first period starts at cnt=0.
- Arithmetic saturates as described; duty_cur never over- or underflows except the defined sawtooth wrap.

## Timing
- Reset (async assert, sync release) values: pwm_out 0, duty_cur 0, period_done 0, state 00, and all counters 0.
- A reset asserted mid-period takes effect immediately. Operation restarts at cnt=0 on the first edge after release.
- Period length is PRESCALE·2^RES_BITS clk cycles.
- pwm_out lags cnt by 1 clk.
- A duty_in change appears in duty_cur on the cycle after the next wrap. It appears in pwm_out one cycle later.
- Ramp: one duty step every STEP_PERIODS periods.
  - Full triangle cycle = 2·(2^RES_BITS-1)·STEP_PERIODS periods.
  - Full sawtooth cycle = 2^RES_BITS·STEP_PERIODS periods.
- Simultaneous wrap and en falling: en wins; no wrap action is taken.
- mode or duty_in changes between wraps are ignored until the next wrap.

## Test plan
- Reset behaviour: PRESCALE=2, RES_BITS=4, reset low mid-run → all outputs 0 immediately. After release with en=1, mode=00, duty_in=4, duty_cur=4 one cycle after the first wrap (cycle 32).
- Manual duty: duty 4 → pwm_out high for exactly 8 of every 32 clks. duty 0 → never high. duty 15 → high 30/32 clks. period_done pulses once every 32 clks.
- Mid-period duty change: change duty_in 4 → 12 at cnt=6 → the current period still shows 8 high clks, and the next period shows 24.
- Triangle ramp: STEP_PERIODS=1, mode=01 from duty 0 → duty_cur sequence 0,1,...,15,14,...,0,1 with one step per wrap, and state toggling 01↔10 at 15 and 0.
- Sawtooth ramp: STEP_PERIODS=2, mode=10 → duty_cur increments every 2 periods, 15→0 wrap, state stays 01.
- Enable gating: en low for 10 clks mid-ramp → pwm_out 0 and period_done silent, duty_cur and state held. After en rises, the first period_done comes 32 clks later.
